// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot/run controller: FSM states,
// registered control-flag bundle and the riscv-tests exit syscall number.
package boot_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } state_t;

    // Every single-bit output of the controller, registered together.
    typedef struct packed {
        logic load_ready;
        logic cpu_reset;
        logic mem_en;
        logic busy;
        logic done;
        logic pass;
        logic timeout;
        logic load_err;
    } ctrl_flags_t;

    localparam ctrl_flags_t FLAGS_RESET = '{cpu_reset: 1'b1, default: 1'b0};

    localparam int RISCV_EXIT_SYSCALL = 93;
    localparam int WORD_SHIFT         = 2;

endpackage

// File: rtl/boot_run_controller_if.sv
// Bus between host/loader, boot_run_controller and the processor preload port.
// master = controller side, slave = host/processor side.
interface boot_run_controller_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic [WIDTH-1:0] expected_a0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] a7;
    logic             cpu_reset;
    logic             mem_en;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             load_err;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  start, load_valid, load_data, load_last, expected_a0, a0, gp, a7,
        output load_ready, cpu_reset, mem_en, mem_addr, mem_data,
               busy, done, pass, timeout, load_err, cycle_count
    );

    modport slave (
        output start, load_valid, load_data, load_last, expected_a0, a0, gp, a7,
        input  load_ready, cpu_reset, mem_en, mem_addr, mem_data,
               busy, done, pass, timeout, load_err, cycle_count
    );
endinterface

// File: rtl/boot_run_controller_run_monitor.sv
// Run-phase monitor: saturating run-cycle counter, timeout compare and
// pass/fail criterion (a0 match by default, riscv-tests exit if RISCV_TESTS_EN).
module run_monitor
    import boot_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_expected_a0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_gp,
    input  logic [WIDTH-1:0] i_a7,
    output logic [CNT_W-1:0] o_count,
    output logic             o_pass_hit,
    output logic             o_fail_hit,
    output logic             o_timeout_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    assign w_count_next = (r_count == '1) ? r_count : r_count + CNT_W'(1);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= w_count_next;
        end
    end

    assign o_count       = r_count;
    // Compared against the post-increment value so DONE reports exactly TIMEOUT_CYCLES.
    assign o_timeout_hit = i_run && (w_count_next == CNT_W'(TIMEOUT_CYCLES));

`ifdef RISCV_TESTS_EN
    logic w_exit_call;
    logic w_unused_inputs;

    assign w_exit_call     = (i_a7 == WIDTH'(RISCV_EXIT_SYSCALL));
    assign o_pass_hit      = i_run && w_exit_call && (i_gp == WIDTH'(1));
    assign o_fail_hit      = i_run && w_exit_call && (i_gp != WIDTH'(1));
    assign w_unused_inputs = ^{i_expected_a0, i_a0};
`else
    logic [WIDTH-1:0] r_expected_a0;
    logic             w_unused_inputs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_expected_a0 <= '0;
        end else if (i_clear) begin
            r_expected_a0 <= i_expected_a0;
        end
    end

    assign o_pass_hit      = i_run && (i_a0 == r_expected_a0);
    assign o_fail_hit      = 1'b0;
    assign w_unused_inputs = ^{i_gp, i_a7};
`endif

endmodule

// File: rtl/boot_run_controller.sv
// Load/hold/run sequencer for the 2-stage core: preloads memory, releases reset,
// and reports PASS/FAIL/TIMEOUT. Optional riscv-tests exit check: RISCV_TESTS_EN.
module boot_run_controller
    import boot_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int RESET_HOLD     = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 32
) (
    input logic                   clock,
    input logic                   reset,
    boot_run_controller_if.master bus
);

    localparam int IDX_W  = $clog2(MEM_WORDS + 1);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    state_t            r_state, w_state_next;
    ctrl_flags_t       r_flags, w_flags_next;
    logic [IDX_W-1:0]  r_index, w_index_next;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
    logic              r_draining, w_draining_next;
    logic [WIDTH-1:0]  r_mem_addr, w_mem_addr_next;
    logic [WIDTH-1:0]  r_mem_data, w_mem_data_next;

    logic w_accept;
    logic w_start_ok;
    logic w_pass_hit;
    logic w_fail_hit;
    logic w_timeout_hit;

    assign w_accept   = bus.load_valid && r_flags.load_ready;
    assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));

    run_monitor #(
        .WIDTH          (WIDTH),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_monitor (
        .clock          (clock),
        .reset          (reset),
        .i_clear        (w_start_ok),
        .i_run          (r_state == RUN),
        .i_expected_a0  (bus.expected_a0),
        .i_a0           (bus.a0),
        .i_gp           (bus.gp),
        .i_a7           (bus.a7),
        .o_count        (bus.cycle_count),
        .o_pass_hit     (w_pass_hit),
        .o_fail_hit     (w_fail_hit),
        .o_timeout_hit  (w_timeout_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_flags    <= FLAGS_RESET;
            r_index    <= '0;
            r_hold_cnt <= '0;
            r_draining <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_flags    <= w_flags_next;
            r_index    <= w_index_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_draining <= w_draining_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_data <= w_mem_data_next;
        end
    end

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        w_state_next        = r_state;
        w_flags_next        = r_flags;
        w_flags_next.mem_en = 1'b0;
        w_index_next        = r_index;
        w_hold_cnt_next     = r_hold_cnt;
        w_draining_next     = r_draining;
        w_mem_addr_next     = r_mem_addr;
        w_mem_data_next     = r_mem_data;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next          = LOAD;
                    w_index_next          = '0;
                    w_draining_next       = 1'b0;
                    w_flags_next.pass     = 1'b0;
                    w_flags_next.timeout  = 1'b0;
                    w_flags_next.load_err = 1'b0;
                end
            end
            LOAD: begin
                // r_draining marks the cycle in which the last word's write is on the port.
                if (r_draining) begin
                    w_state_next    = HOLD;
                    w_hold_cnt_next = '0;
                end else if (w_accept) begin
                    if (r_index == IDX_W'(MEM_WORDS)) begin
                        w_flags_next.load_err = 1'b1;
                        w_state_next          = DONE;
                    end else begin
                        w_flags_next.mem_en = 1'b1;
                        w_mem_addr_next     = WIDTH'(r_index) << WORD_SHIFT;
                        w_mem_data_next     = bus.load_data;
                        w_index_next        = r_index + IDX_W'(1);
                        w_draining_next     = bus.load_last;
                    end
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (w_pass_hit) begin
                    w_flags_next.pass = 1'b1;
                    w_state_next      = DONE;
                end else if (w_fail_hit) begin
                    w_state_next = DONE;
                end else if (w_timeout_hit) begin
                    w_flags_next.timeout = 1'b1;
                    w_state_next         = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_flags_next.load_ready = (w_state_next == LOAD) && !w_draining_next;
        w_flags_next.cpu_reset  = (w_state_next != RUN);
        w_flags_next.busy       = (w_state_next == LOAD) || (w_state_next == HOLD) ||
                                  (w_state_next == RUN);
        w_flags_next.done       = (w_state_next == DONE);
    end

    assign bus.load_ready = r_flags.load_ready;
    assign bus.cpu_reset  = r_flags.cpu_reset;
    assign bus.mem_en     = r_flags.mem_en;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.busy       = r_flags.busy;
    assign bus.done       = r_flags.done;
    assign bus.pass       = r_flags.pass;
    assign bus.timeout    = r_flags.timeout;
    assign bus.load_err   = r_flags.load_err;

endmodule

// File: tb/tb_boot_run_controller.sv
// Directed bench for boot_run_controller (MEM_WORDS=4 so overflow is reachable).
// Covers the RISCV_TESTS_EN build as well as the default a0 criterion.
module tb_boot_run_controller;

    localparam int WIDTH          = 32;
    localparam int CNT_W          = 32;
    localparam int MEM_WORDS      = 4;
    localparam int RESET_HOLD     = 2;
    localparam int TIMEOUT_CYCLES = 5000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    boot_run_controller_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    boot_run_controller #(
        .WIDTH          (WIDTH),
        .MEM_WORDS      (MEM_WORDS),
        .RESET_HOLD     (RESET_HOLD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Write and run-start recorder, sampled on the inactive edge.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          cyc           = 0;
    int          last_wr_cyc   = 0;
    int          first_run_cyc = 0;
    bit          run_seen      = 1'b0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (bus.mem_en === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_data);
            last_wr_cyc = cyc;
        end
        if (bus.cpu_reset === 1'b0 && !run_seen) begin
            run_seen      = 1'b1;
            first_run_cyc = cyc;
        end
    end

    function automatic logic [31:0] q_at(input int kind, input int i);
        if (kind == 0) return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        run_seen = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] exp);
        bus.expected_a0 = exp;
        bus.start       = 1'b1;
        @(negedge clock);
        bus.start       = 1'b0;
    endtask

    task automatic load_burst(input int n, input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = base + step * 32'(i);
            bus.load_last  = (i == n - 1);
            @(negedge clock);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic clear_criteria();
        bus.a0 = '0;
        bus.gp = '0;
        bus.a7 = '0;
    endtask

    task automatic drive_pass(input logic [31:0] exp);
`ifdef RISCV_TESTS_EN
        bus.a7 = 32'd93;
        bus.gp = 32'd1;
        bus.a0 = exp ^ 32'hFFFF_FFFF;
`else
        bus.a0 = exp;
`endif
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cpu_reset === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++;
        if (bus.cpu_reset !== 1'b1) begin
            bad++; $display("FAIL reset_cpu_reset: got %b want 1", bus.cpu_reset);
        end
        total++;
        if ({bus.load_ready, bus.mem_en, bus.busy, bus.done, bus.pass, bus.timeout,
             bus.load_err} !== 7'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000000", {bus.load_ready,
                bus.mem_en, bus.busy, bus.done, bus.pass, bus.timeout, bus.load_err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_data, bus.cycle_count} !== 96'h0) begin
            bad++; $display("FAIL reset_words: got %h/%h/%h want 0", bus.mem_addr,
                bus.mem_data, bus.cycle_count);
        end
        reset          = 1'b0;
        bus.load_valid = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({bus.busy, bus.load_ready, bus.mem_en, bus.cpu_reset} !== 4'b0001) begin
            bad++; $display("FAIL idle_ignores_valid: got %b want 0001",
                {bus.busy, bus.load_ready, bus.mem_en, bus.cpu_reset});
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_basic_run();
        bit ok;
        clear_log();
        clear_criteria();
        do_start(32'd144);
        load_burst(4, 32'h13, 32'h0);
        wait_run(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_run_start: got no RUN want RUN"); end
        repeat (19) @(negedge clock);
        total++;
        if (bus.done !== 1'b0 || bus.cycle_count !== 32'd19) begin
            bad++; $display("FAIL basic_pre_pass: got done=%b cnt=%0d want done=0 cnt=19",
                bus.done, bus.cycle_count);
        end
        drive_pass(32'd144);
        @(negedge clock);
        clear_criteria();
        total++;
        if (wr_addr_q.size() !== 4) begin
            bad++; $display("FAIL basic_write_count: got %0d want 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_at(0, i) !== 32'(i * 4) || q_at(1, i) !== 32'h13) begin
                bad++; $display("FAIL basic_write%0d: got %h:%h want %h:00000013", i,
                    q_at(0, i), q_at(1, i), 32'(i * 4));
            end
        end
        total++;
        if (first_run_cyc - last_wr_cyc !== RESET_HOLD + 1) begin
            bad++; $display("FAIL basic_hold_gap: got %0d want %0d",
                first_run_cyc - last_wr_cyc, RESET_HOLD + 1);
        end
        total++;
        if ({bus.done, bus.pass, bus.timeout, bus.load_err, bus.busy, bus.cpu_reset}
            !== 6'b110001) begin
            bad++; $display("FAIL basic_result: got %b want 110001", {bus.done, bus.pass,
                bus.timeout, bus.load_err, bus.busy, bus.cpu_reset});
        end
        total++;
        if (bus.cycle_count !== 32'd20) begin
            bad++; $display("FAIL basic_cycle_count: got %0d want 20", bus.cycle_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit pat [0:6];
        int k;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        clear_log();
        drive_pass(32'd7);
        do_start(32'd7);
        total++;
        if ({bus.done, bus.pass, bus.load_ready, bus.busy} !== 4'b0011) begin
            bad++; $display("FAIL bp_restart_clears: got %b want 0011",
                {bus.done, bus.pass, bus.load_ready, bus.busy});
        end
        k = 0;
        for (int c = 0; c < 7; c++) begin
            bus.load_valid = pat[c];
            bus.load_data  = 32'hA0 + 32'(k);
            bus.load_last  = (k == 3);
            bus.start      = (c == 1);
            @(negedge clock);
            if (pat[c]) k++;
        end
        bus.start      = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD;
        wait_done(100, ok);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_done: got done=0 want done=1"); end
        total++;
        if (wr_addr_q.size() !== 4) begin
            bad++; $display("FAIL bp_write_count: got %0d want 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_at(0, i) !== 32'(i * 4) || q_at(1, i) !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL bp_write%0d: got %h:%h want %h:%h", i, q_at(0, i),
                    q_at(1, i), 32'(i * 4), 32'hA0 + 32'(i));
            end
        end
        total++;
        if (bus.pass !== 1'b1 || bus.cycle_count !== 32'd1) begin
            bad++; $display("FAIL bp_first_cycle_pass: got pass=%b cnt=%0d want 1/1",
                bus.pass, bus.cycle_count);
        end
        clear_criteria();
    endtask

    task automatic test_timeout();
        bit ok;
        clear_log();
        clear_criteria();
        do_start(32'd144);
        load_burst(1, 32'h6F, 32'h0);
        wait_done(TIMEOUT_CYCLES + 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_done: got done=0 want done=1"); end
        total++;
        if ({bus.timeout, bus.pass, bus.load_err, bus.cpu_reset} !== 4'b1001) begin
            bad++; $display("FAIL to_flags: got %b want 1001",
                {bus.timeout, bus.pass, bus.load_err, bus.cpu_reset});
        end
        total++;
        if (bus.cycle_count !== 32'd5000) begin
            bad++; $display("FAIL to_cycle_count: got %0d want 5000", bus.cycle_count);
        end
        total++;
        if (wr_addr_q.size() !== 1 || q_at(0, 0) !== 32'h0 || q_at(1, 0) !== 32'h6F) begin
            bad++; $display("FAIL to_single_word: got n=%0d %h:%h want 1 0:6f",
                wr_addr_q.size(), q_at(0, 0), q_at(1, 0));
        end
        repeat (3) @(negedge clock);
        total++;
        if (bus.cycle_count !== 32'd5000 || bus.timeout !== 1'b1) begin
            bad++; $display("FAIL to_hold: got cnt=%0d timeout=%b want 5000/1",
                bus.cycle_count, bus.timeout);
        end
    endtask

    task automatic test_overflow();
        clear_log();
        drive_pass(32'd1);
        do_start(32'd1);
        load_burst(5, 32'h100, 32'h4);
        total++;
        if (wr_addr_q.size() !== 4) begin
            bad++; $display("FAIL ovf_write_count: got %0d want 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_at(0, i) !== 32'(i * 4)) begin
                bad++; $display("FAIL ovf_addr%0d: got %h want %h", i, q_at(0, i), 32'(i * 4));
            end
        end
        total++;
        if ({bus.done, bus.load_err, bus.pass, bus.timeout, bus.busy} !== 5'b11000) begin
            bad++; $display("FAIL ovf_flags: got %b want 11000",
                {bus.done, bus.load_err, bus.pass, bus.timeout, bus.busy});
        end
        repeat (5) @(negedge clock);
        total++;
        if (run_seen !== 1'b0 || bus.cpu_reset !== 1'b1) begin
            bad++; $display("FAIL ovf_no_run: got run_seen=%b cpu_reset=%b want 0/1",
                run_seen, bus.cpu_reset);
        end
        clear_criteria();
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_log();
        clear_criteria();
        do_start(32'd55);
        load_burst(3, 32'h200, 32'h1);
        wait_run(ok);
        repeat (9) @(negedge clock);
        total++;
        if (!ok || bus.cycle_count !== 32'd9 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL ar_running: got ok=%b cnt=%0d busy=%b want 1/9/1",
                ok, bus.cycle_count, bus.busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.cpu_reset, bus.busy, bus.done, bus.pass, bus.timeout, bus.load_err,
             bus.load_ready, bus.mem_en} !== 8'b1000_0000 || bus.cycle_count !== 32'd0) begin
            bad++; $display("FAIL ar_immediate: got %b cnt=%0d want 10000000 cnt=0",
                {bus.cpu_reset, bus.busy, bus.done, bus.pass, bus.timeout, bus.load_err,
                 bus.load_ready, bus.mem_en}, bus.cycle_count);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clear_log();
        drive_pass(32'd55);
        do_start(32'd55);
        load_burst(2, 32'h300, 32'h1);
        wait_done(100, ok);
        total++;
        if (!ok || bus.pass !== 1'b1 || bus.cycle_count !== 32'd1) begin
            bad++; $display("FAIL ar_reload_pass: got ok=%b pass=%b cnt=%0d want 1/1/1",
                ok, bus.pass, bus.cycle_count);
        end
        total++;
        if (wr_addr_q.size() !== 2 || q_at(0, 0) !== 32'h0 || q_at(0, 1) !== 32'h4 ||
            q_at(1, 1) !== 32'h301) begin
            bad++; $display("FAIL ar_reload_writes: got n=%0d %h %h:%h want 2 0 4:301",
                wr_addr_q.size(), q_at(0, 0), q_at(0, 1), q_at(1, 1));
        end
        clear_criteria();
    endtask

`ifdef RISCV_TESTS_EN
    task automatic test_riscv_exit();
        bit ok;
        clear_criteria();
        bus.a0 = 32'd5;
        bus.a7 = 32'd93;
        bus.gp = 32'd3;
        do_start(32'd5);
        load_burst(1, 32'h13, 32'h0);
        wait_done(100, ok);
        total++;
        if (!ok || {bus.pass, bus.timeout} !== 2'b00 || bus.cycle_count !== 32'd1) begin
            bad++; $display("FAIL rv_fail_exit: got ok=%b pass=%b to=%b cnt=%0d want 1/0/0/1",
                ok, bus.pass, bus.timeout, bus.cycle_count);
        end
        bus.gp = 32'd1;
        bus.a0 = 32'd0;
        do_start(32'd5);
        load_burst(1, 32'h13, 32'h0);
        wait_done(100, ok);
        total++;
        if (!ok || {bus.pass, bus.timeout} !== 2'b10) begin
            bad++; $display("FAIL rv_pass_exit: got ok=%b pass=%b to=%b want 1/1/0",
                ok, bus.pass, bus.timeout);
        end
        clear_criteria();
    endtask
`else
    task automatic test_a0_only();
        bit ok;
        clear_criteria();
        bus.a7 = 32'd93;
        bus.gp = 32'd3;
        do_start(32'd9);
        load_burst(1, 32'h13, 32'h0);
        wait_run(ok);
        repeat (30) @(negedge clock);
        total++;
        if (!ok || bus.done !== 1'b0) begin
            bad++; $display("FAIL a0_ignores_exit: got ok=%b done=%b want 1/0", ok, bus.done);
        end
        bus.a0 = 32'd9;
        @(negedge clock);
        total++;
        if ({bus.done, bus.pass} !== 2'b11 || bus.cycle_count !== 32'd31) begin
            bad++; $display("FAIL a0_late_pass: got done=%b pass=%b cnt=%0d want 1/1/31",
                bus.done, bus.pass, bus.cycle_count);
        end
        clear_criteria();
    endtask
`endif

    initial begin
        bus.start       = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_last   = 1'b0;
        bus.expected_a0 = '0;
        clear_criteria();
        test_reset();
        test_basic_run();
        test_backpressure();
        test_timeout();
        test_overflow();
        test_async_reset();
`ifdef RISCV_TESTS_EN
        test_riscv_exit();
`else
        test_a0_only();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want completion before 1ms");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
